// File: rtl/logistic_orbit_marker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logistic_orbit_marker_pkg
// Description : Shared constants and state type for the logistic-map orbit
//               marker (Q1.16 iterate format, row mapping, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package logistic_orbit_marker_pkg;

  // Q1.16 iterate format: 1 integer bit, 16 fraction bits.
  localparam int                X_W      = 17;
  localparam logic [X_W-1:0]    ONE      = 17'h10000;

  // Row mapping: row = x >> X_SHIFT, truncated to ROW_BITS.
  localparam int                ROW_BITS = 9;
  localparam int                X_SHIFT  = 8;

  // Length and distinct-count widths.
  localparam int                LEN_W    = 9;
  localparam int                CNT_W    = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    PLOT = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage : logistic_orbit_marker_pkg
`default_nettype wire

// File: rtl/logistic_orbit_marker_bank.sv
`default_nettype none
// ============================================================================
// Module      : orbit_bitmap_bank
// Description : Ping-pong pair of row bitmaps. The bank selected by
//               disp_sel_i is displayed (registered read); the other bank is
//               the fill bank (clear, set-bit with prior-bit lookup).
// Revision    : 1.0 - initial release
// ============================================================================
module orbit_bitmap_bank
  import logistic_orbit_marker_pkg::*;
#(
  parameter int BANK_ROW_BITS = ROW_BITS
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     wr_en_i,
  input  logic [BANK_ROW_BITS-1:0] wr_row_i,
  input  logic                     disp_sel_i,
  input  logic [BANK_ROW_BITS-1:0] rd_row_i,
  output logic                     prior_o,
  output logic                     rd_hit_o
);

  localparam int DEPTH = 1 << BANK_ROW_BITS;

  logic [1:0][DEPTH-1:0] bank_q;
  logic                  rd_hit_q;
  logic                  w_fill_sel;

  // The fill bank is always the one not on display, so the raster never
  // sees a column that is still being built.
  assign w_fill_sel = ~disp_sel_i;
  assign prior_o    = bank_q[w_fill_sel][wr_row_i];
  assign rd_hit_o   = rd_hit_q;

  // Bank storage and registered display-bank read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_q   <= '0;
      rd_hit_q <= 1'b0;
    end else begin
      rd_hit_q <= bank_q[disp_sel_i][rd_row_i];
      if (clr_i) begin
        bank_q[w_fill_sel] <= '0;
      end else if (wr_en_i) begin
        bank_q[w_fill_sel][wr_row_i] <= 1'b1;
      end
    end
  end

endmodule : orbit_bitmap_bank
`default_nettype wire

// File: rtl/logistic_orbit_marker.sv
`default_nettype none
// ============================================================================
// Module      : logistic_orbit_marker
// Description : Consumes a column of Q1.16 logistic-map iterates, drops a
//               warm-up run, marks visited display rows in a ping-pong row
//               bitmap and reports the number of distinct rows hit.
// Revision    : 1.0 - initial release
// ============================================================================
module logistic_orbit_marker
  import logistic_orbit_marker_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [LEN_W-1:0]    skip_len,
  input  logic [LEN_W-1:0]    plot_len,
  input  logic                x_valid,
  input  logic [X_W-1:0]      x,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    distinct,
  input  logic [ROW_BITS-1:0] rd_row,
  output logic                rd_hit,
  output logic                disp_sel
);

  state_e               state_q,    state_d;
  logic [LEN_W-1:0]     skip_rem_q, skip_rem_d;
  logic [LEN_W-1:0]     plot_rem_q, plot_rem_d;
  logic [CNT_W-1:0]     cnt_q,      cnt_d;
  logic [CNT_W-1:0]     distinct_q, distinct_d;
  logic                 disp_sel_q, disp_sel_d;

  logic                 w_clr;
  logic                 w_wr_en;
  logic                 w_prior;
  logic [ROW_BITS-1:0]  w_row;

  assign w_row    = ROW_BITS'(x >> X_SHIFT);

  assign busy     = (state_q == SKIP) || (state_q == PLOT);
  assign done     = (state_q == DONE);
  assign distinct = distinct_q;
  assign disp_sel = disp_sel_q;

  orbit_bitmap_bank #(
    .BANK_ROW_BITS (ROW_BITS)
  ) u_bank (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .clr_i      (w_clr),
    .wr_en_i    (w_wr_en),
    .wr_row_i   (w_row),
    .disp_sel_i (disp_sel_q),
    .rd_row_i   (rd_row),
    .prior_o    (w_prior),
    .rd_hit_o   (rd_hit)
  );

  // Next-state, counter and bank-control logic for one column.
  always_comb begin
    state_d    = state_q;
    skip_rem_d = skip_rem_q;
    plot_rem_d = plot_rem_q;
    cnt_d      = cnt_q;
    distinct_d = distinct_q;
    disp_sel_d = disp_sel_q;
    w_clr      = 1'b0;
    w_wr_en    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          w_clr      = 1'b1;
          skip_rem_d = skip_len;
          plot_rem_d = plot_len;
          cnt_d      = '0;
          if (skip_len != '0) begin
            state_d = SKIP;
          end else if (plot_len != '0) begin
            state_d = PLOT;
          end else begin
            // Empty column: publish the freshly cleared bank at once.
            state_d    = DONE;
            disp_sel_d = ~disp_sel_q;
            distinct_d = '0;
          end
        end
      end

      SKIP: begin
        if (x_valid) begin
          skip_rem_d = skip_rem_q - LEN_W'(1);
          if (skip_rem_q == LEN_W'(1)) begin
            if (plot_rem_q != '0) begin
              state_d = PLOT;
            end else begin
              // Nothing to plot after warm-up: finish with an empty column
              // rather than waiting forever in PLOT.
              state_d    = DONE;
              disp_sel_d = ~disp_sel_q;
              distinct_d = '0;
            end
          end
        end
      end

      PLOT: begin
        if (x_valid) begin
          w_wr_en    = 1'b1;
          plot_rem_d = plot_rem_q - LEN_W'(1);
          if (!w_prior) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (plot_rem_q == LEN_W'(1)) begin
            state_d    = DONE;
            disp_sel_d = ~disp_sel_q;
            distinct_d = cnt_d;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      skip_rem_q <= '0;
      plot_rem_q <= '0;
      cnt_q      <= '0;
      distinct_q <= '0;
      disp_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_rem_q <= skip_rem_d;
      plot_rem_q <= plot_rem_d;
      cnt_q      <= cnt_d;
      distinct_q <= distinct_d;
      disp_sel_q <= disp_sel_d;
    end
  end

endmodule : logistic_orbit_marker
`default_nettype wire

// File: tb/tb_logistic_orbit_marker.sv
`default_nettype none
// ============================================================================
// Module      : tb_logistic_orbit_marker
// Description : Directed self-checking bench for logistic_orbit_marker with a
//               column-level reference model and per-cycle output compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logistic_orbit_marker;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  skip_len = '0;
  logic [8:0]  plot_len = '0;
  logic        x_valid = 1'b0;
  logic [16:0] x = '0;
  logic        busy;
  logic        done;
  logic [9:0]  distinct;
  logic [8:0]  rd_row = '0;
  logic        rd_hit;
  logic        disp_sel;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  logistic_orbit_marker dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .skip_len (skip_len),
    .plot_len (plot_len),
    .x_valid  (x_valid),
    .x        (x),
    .busy     (busy),
    .done     (done),
    .distinct (distinct),
    .rd_row   (rd_row),
    .rd_hit   (rd_hit),
    .disp_sel (disp_sel)
  );

  always #5 CLK = ~CLK;

  // ---------------- column-level reference model ----------------
  bit [511:0] m_visit = '0;   // rows visited by the column being built
  bit [511:0] m_disp  = '0;   // rows of the last published column
  int         m_skip  = 0;
  int         m_plot  = 0;
  bit         m_active = 1'b0;
  bit         m_done  = 1'b0;
  bit         m_sel   = 1'b0;
  int         m_dist  = 0;
  bit         m_rd    = 1'b0;

  function automatic void finish_col();
    m_disp   = m_visit;
    m_dist   = $countones(m_visit);
    m_sel    = ~m_sel;
    m_done   = 1'b1;
    m_active = 1'b0;
  endfunction

  always @(negedge RST) begin
    m_visit = '0; m_disp = '0; m_skip = 0; m_plot = 0;
    m_active = 1'b0; m_done = 1'b0; m_sel = 1'b0; m_dist = 0; m_rd = 1'b0;
  end

  always @(posedge CLK) begin
    if (RST) begin
      m_rd   = m_disp[rd_row];
      m_done = 1'b0;
      if (!m_active) begin
        if (start) begin
          m_visit = '0;
          m_skip  = int'(skip_len);
          m_plot  = int'(plot_len);
          if (m_skip == 0 && m_plot == 0) finish_col();
          else m_active = 1'b1;
        end
      end else if (x_valid) begin
        if (m_skip > 0) begin
          m_skip--;
          if (m_skip == 0 && m_plot == 0) finish_col();
        end else begin
          m_visit[x[16:8]] = 1'b1;
          m_plot--;
          if (m_plot == 0) finish_col();
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("cyc_busy",     int'(busy),     int'(m_active));
      chk("cyc_done",     int'(done),     int'(m_done));
      chk("cyc_distinct", int'(distinct), m_dist);
      chk("cyc_disp_sel", int'(disp_sel), int'(m_sel));
      chk("cyc_rd_hit",   int'(rd_hit),   int'(m_rd));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic start_col(input int s, input int p);
    start    = 1'b1;
    skip_len = 9'(s);
    plot_len = 9'(p);
    cyc();
    start    = 1'b0;
  endtask

  task automatic send(input logic [16:0] xv);
    x_valid = 1'b1;
    x       = xv;
    cyc();
    x_valid = 1'b0;
  endtask

  task automatic rd(input int row, input int exp, input string name);
    rd_row = 9'(row);
    cyc();
    chk(name, int'(rd_hit), exp);
  endtask

  int ones;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) cyc();
    chk("rst_busy",     int'(busy),     0);
    chk("rst_done",     int'(done),     0);
    chk("rst_distinct", int'(distinct), 0);
    chk("rst_disp_sel", int'(disp_sel), 0);
    chk("rst_rd_hit",   int'(rd_hit),   0);
    RST = 1'b1;
    cmp_en = 1'b1;
    cyc();

    // Fixed point at 0.5 -> row 128.
    start_col(0, 4);
    repeat (4) send(17'h08000);
    chk("fp_done", int'(done), 1);
    chk("fp_distinct", int'(distinct), 1);
    chk("fp_disp_sel", int'(disp_sel), 1);
    rd(128, 1, "fp_row128");
    rd(127, 0, "fp_row127");

    // Period-2 orbit with junk warm-up.
    start_col(3, 6);
    repeat (3) send(17'h1FFFF);
    chk("p2_busy_after_skip", int'(busy), 1);
    repeat (3) begin
      send(17'h04000);
      send(17'h0C000);
    end
    chk("p2_done", int'(done), 1);
    chk("p2_distinct", int'(distinct), 2);
    rd(64,  1, "p2_row64");
    rd(192, 1, "p2_row192");
    rd(511, 0, "p2_row511_junk");
    rd(128, 0, "p2_row128");

    // x = 1.0 -> row 256.
    start_col(0, 1);
    send(17'h10000);
    chk("one_done", int'(done), 1);
    chk("one_distinct", int'(distinct), 1);
    rd(256, 1, "one_row256");
    rd(255, 0, "one_row255");

    // Empty column: done the cycle after start, display all-zero.
    start_col(0, 0);
    chk("empty_done", int'(done), 1);
    chk("empty_distinct", int'(distinct), 0);
    chk("empty_disp_sel", int'(disp_sel), 0);
    ones = 0;
    for (int r = 0; r < 512; r++) begin
      rd_row = 9'(r);
      cyc();
      if (rd_hit === 1'b1) ones++;
    end
    chk("empty_all_zero", ones, 0);

    // Ping-pong: A at row 128, B at row 64 read mid-fill.
    start_col(0, 2);
    repeat (2) send(17'h08000);
    start_col(0, 3);
    repeat (2) send(17'h04000);
    repeat (2) cyc();
    rd(128, 1, "pp_mid_row128");
    rd(64,  0, "pp_mid_row64");
    chk("pp_mid_busy", int'(busy), 1);
    send(17'h04000);
    chk("pp_b_done", int'(done), 1);
    rd(64,  1, "pp_b_row64");
    rd(128, 0, "pp_b_row128");

    // Start while busy is ignored; start in DONE is accepted directly.
    start_col(1, 3);
    send(17'h1FFFF);
    send(17'h08000);
    start = 1'b1; skip_len = 9'd0; plot_len = 9'd1;
    send(17'h04000);
    start = 1'b0;
    chk("ign_not_done_yet", int'(done), 0);
    send(17'h0C000);
    chk("ign_done", int'(done), 1);
    chk("ign_distinct", int'(distinct), 3);
    start_col(0, 1);
    chk("chain_busy", int'(busy), 1);
    send(17'h10000);
    chk("chain_done", int'(done), 1);
    chk("chain_distinct", int'(distinct), 1);

    // Asynchronous reset mid-PLOT, off the clock edge.
    start_col(0, 5);
    send(17'h08000);
    send(17'h04000);
    #1;
    RST = 1'b0;
    #1;
    chk("ar_busy",     int'(busy),     0);
    chk("ar_done",     int'(done),     0);
    chk("ar_distinct", int'(distinct), 0);
    chk("ar_disp_sel", int'(disp_sel), 0);
    chk("ar_rd_hit",   int'(rd_hit),   0);
    cyc();
    RST = 1'b1;
    cyc();
    rd(128, 0, "ar_row128");
    rd(256, 0, "ar_row256");
    ones = 0;
    for (int r = 0; r < 512; r++) begin
      rd_row = 9'(r);
      cyc();
      if (rd_hit === 1'b1) ones++;
    end
    chk("ar_all_zero", ones, 0);
    repeat (3) send(17'h08000);
    chk("ar_x_ignored_busy", int'(busy), 0);
    rd(128, 0, "ar_x_ignored_row128");
    cyc();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_logistic_orbit_marker
`default_nettype wire
